// File: rtl/diag_pkg.sv
// Shared encodings for the diag monitor: FSM state, failure cause, default sample width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package diag_pkg;

  localparam int DEFAULT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EQUAL = 2'd1,
    AHEAD = 2'd2,
    FAIL  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    ORDER = 2'd1,
    HOLD  = 2'd2
  } cause_e;

endpackage

// File: rtl/diag_monitor_if.sv
// Sample bus from the producer under observation into the monitor.
// Latency: n/a (wires only).
// Backpressure: none; the monitor observes every valid sample.
interface diag_monitor_if #(
  parameter int W = diag_pkg::DEFAULT_W
) ();

  logic         valid;
  logic [W-1:0] x;
  logic [W-1:0] y;

  modport master (output valid, x, y);
  modport slave  (input  valid, x, y);

endinterface

// File: rtl/diag_sat_counter.sv
// Saturating up-counter of accepted samples.
// Latency: count reflects an increment one cycle after inc.
// Backpressure: none; increments are dropped once the counter is at its maximum.
module diag_sat_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] count_q = '0;

  // Count up on each increment request, holding at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc && (count_q != CNT_MAX)) begin
      count_q <= count_q + CNT_ONE;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/diag_monitor.sv
// Checks a producer's x/y stream for ordering (x >= y) and y-hold while ahead; sticky FAIL.
// Latency: a sample in cycle N shows in the registered outputs in cycle N+1.
// Backpressure: none; optional fail_x/fail_y trace ports under DIAG_MONITOR_TRACE_EN.
module diag_monitor
  import diag_pkg::*;
#(
  parameter int W  = DEFAULT_W,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  diag_monitor_if.slave smp,
  output logic [1:0]    state,
  output logic          ok,
  output logic [1:0]    cause,
  output logic [CW-1:0] sample_cnt
`ifdef DIAG_MONITOR_TRACE_EN
  ,
  output logic [W-1:0]  fail_x,
  output logic [W-1:0]  fail_y
`endif
);

  // Initialisers match the reset values so a formal run without a reset cycle starts sane.
  state_e       state_q  = IDLE;
  cause_e       cause_q  = NONE;
  logic         ok_q     = 1'b1;
  logic [W-1:0] prev_y_q = '0;

  state_e state_d;
  cause_e cause_d;
  logic   ok_d;
  logic   enter_fail;

  // State register: all FSM-related state, with reset discarding any simultaneous sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cause_q  <= NONE;
      ok_q     <= 1'b1;
      prev_y_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      ok_q    <= ok_d;
      // Previous y tracks every accepted sample, including the one that enters FAIL.
      if (smp.valid) begin
        prev_y_q <= smp.y;
      end
    end
  end

  // Next-state: ORDER is tested before HOLD so it wins when both apply; FAIL never leaves.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    if (smp.valid) begin
      case (state_q)
        IDLE, EQUAL: begin
          if (smp.x < smp.y) begin
            state_d = FAIL;
            cause_d = ORDER;
          end else if (smp.x == smp.y) begin
            state_d = EQUAL;
          end else begin
            state_d = AHEAD;
          end
        end
        AHEAD: begin
          if (smp.x < smp.y) begin
            state_d = FAIL;
            cause_d = ORDER;
          end else if (smp.y != prev_y_q) begin
            state_d = FAIL;
            cause_d = HOLD;
          end else if (smp.x == smp.y) begin
            state_d = EQUAL;
          end else begin
            state_d = AHEAD;
          end
        end
        FAIL: begin
          state_d = FAIL;
          cause_d = cause_q;
        end
        default: begin
          state_d = state_q;
          cause_d = cause_q;
        end
      endcase
    end
  end

  // Output decode: next value of the registered ok flag and the FAIL-entry strobe.
  always_comb begin
    ok_d       = (state_d != FAIL);
    enter_fail = smp.valid && (state_q != FAIL) && (state_d == FAIL);
  end

  diag_sat_counter #(
    .CW (CW)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (smp.valid),
    .count (sample_cnt)
  );

  assign state = state_q;
  assign cause = cause_q;
  assign ok    = ok_q;

`ifdef DIAG_MONITOR_TRACE_EN
  logic [W-1:0] fail_x_q = '0;
  logic [W-1:0] fail_y_q = '0;

  // Capture the offending sample once, on the transition into FAIL.
  always_ff @(posedge clk) begin
    if (reset) begin
      fail_x_q <= '0;
      fail_y_q <= '0;
    end else if (enter_fail) begin
      fail_x_q <= smp.x;
      fail_y_q <= smp.y;
    end
  end

  assign fail_x = fail_x_q;
  assign fail_y = fail_y_q;
`else
  logic unused_enter_fail;
  assign unused_enter_fail = enter_fail;
`endif

`ifdef FORMAL
  // Safety target for formal: with a well-behaved producer the monitor never trips.
  wire ok_w = ok_q;
  ok_always_high: assert property (@(posedge clk) ok_w);
`endif

endmodule

// File: tb/tb_diag_monitor.sv
module tb_diag_monitor;
  import diag_pkg::*;

  typedef struct {
    logic [1:0] st;
    logic [1:0] ca;
    logic [7:0] c8;
    logic [3:0] c4;
    logic [3:0] fx;
    logic [3:0] fy;
  } exp_t;

  logic clk;
  logic reset;

  diag_monitor_if #(.W(4)) bus ();

  logic [1:0] state_a, cause_a, state_b, cause_b;
  logic       ok_a, ok_b;
  logic [7:0] cnt_a;
  logic [3:0] cnt_b;
`ifdef DIAG_MONITOR_TRACE_EN
  logic [3:0] fx_a, fy_a, fx_b, fy_b;
`endif

  diag_monitor #(.W(4), .CW(8)) dut_a (
    .clk        (clk),
    .reset      (reset),
    .smp        (bus.slave),
    .state      (state_a),
    .ok         (ok_a),
    .cause      (cause_a),
    .sample_cnt (cnt_a)
`ifdef DIAG_MONITOR_TRACE_EN
    ,
    .fail_x     (fx_a),
    .fail_y     (fy_a)
`endif
  );

  diag_monitor #(.W(4), .CW(4)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .smp        (bus.slave),
    .state      (state_b),
    .ok         (ok_b),
    .cause      (cause_b),
    .sample_cnt (cnt_b)
`ifdef DIAG_MONITOR_TRACE_EN
    ,
    .fail_x     (fx_b),
    .fail_y     (fy_b)
`endif
  );

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: one expected record per driven cycle, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cyc++;
        chk("state_a", int'(state_a), int'(e.st));
        chk("cause_a", int'(cause_a), int'(e.ca));
        chk("ok_a",    int'(ok_a),    (e.st != 2'd3) ? 1 : 0);
        chk("cnt_a",   int'(cnt_a),   int'(e.c8));
        chk("state_b", int'(state_b), int'(e.st));
        chk("ok_b",    int'(ok_b),    (e.st != 2'd3) ? 1 : 0);
        chk("cnt_b",   int'(cnt_b),   int'(e.c4));
`ifdef DIAG_MONITOR_TRACE_EN
        chk("fail_x", int'(fx_a), int'(e.fx));
        chk("fail_y", int'(fy_a), int'(e.fy));
`endif
      end
    end
  end

  task automatic step(input bit r, input bit v, input int xi, input int yi,
                      input int st, input int ca, input int c8, input int c4,
                      input int fx, input int fy);
    exp_t e;
    @(negedge clk);
    reset     = r;
    bus.valid = v;
    bus.x     = 4'(xi);
    bus.y     = 4'(yi);
    e.st = 2'(st);
    e.ca = 2'(ca);
    e.c8 = 8'(c8);
    e.c4 = 4'(c4);
    e.fx = 4'(fx);
    e.fy = 4'(fy);
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    bus.valid = 1'b0;
    bus.x     = '0;
    bus.y     = '0;
    //    rst v  x   y   state cause cnt8 cnt4 fx fy
    step(1, 0,  0,  0,  0, 0, 0, 0,  0, 0);   // reset state
    step(0, 1,  0,  0,  1, 0, 1, 1,  0, 0);   // EQUAL
    step(0, 1,  1,  1,  1, 0, 2, 2,  0, 0);   // EQUAL
    step(0, 1,  8,  1,  2, 0, 3, 3,  0, 0);   // AHEAD
    step(0, 1, 12,  1,  2, 0, 4, 4,  0, 0);   // AHEAD, y held
    step(0, 0,  9,  9,  2, 0, 4, 4,  0, 0);   // gap: nothing moves
    step(0, 1, 12,  2,  3, 2, 5, 5, 12, 2);   // HOLD violation
    step(0, 1,  5,  5,  3, 2, 6, 6, 12, 2);   // sticky, still counts
    step(0, 0,  0,  0,  3, 2, 6, 6, 12, 2);   // sticky without valid
    step(1, 1,  5,  5,  0, 0, 0, 0,  0, 0);   // reset beats valid
    step(0, 1,  3,  5,  3, 1, 1, 1,  3, 5);   // ORDER from IDLE
    step(1, 0,  0,  0,  0, 0, 0, 0,  0, 0);
    step(0, 1,  6,  4,  2, 0, 1, 1,  0, 0);   // AHEAD, prev y = 4
    step(0, 1,  2,  7,  3, 1, 2, 2,  2, 7);   // ORDER beats HOLD
    step(1, 0,  0,  0,  0, 0, 0, 0,  0, 0);
    step(0, 1, 15, 15,  1, 0, 1, 1,  0, 0);
    step(0, 1,  0,  0,  1, 0, 2, 2,  0, 0);   // wrap in EQUAL: no hold check
    step(0, 1, 15,  0,  2, 0, 3, 3,  0, 0);   // unsigned max vs 0
    step(0, 1,  0,  0,  1, 0, 4, 4,  0, 0);   // AHEAD -> EQUAL, y held
    step(0, 1, 15,  0,  2, 0, 5, 5,  0, 0);
    step(0, 0,  0,  9,  2, 0, 5, 5,  0, 0);   // gap must not load prev y
    step(0, 1,  9,  0,  2, 0, 6, 6,  0, 0);   // prev y still 0
    step(0, 1,  4,  0,  2, 0, 7, 7,  0, 0);
    step(0, 1,  0,  1,  3, 1, 8, 8,  0, 1);   // ORDER from AHEAD
    // Saturation of the narrow counter, with gaps.
    step(1, 0,  0,  0,  0, 0, 0, 0,  0, 0);
    for (int i = 1; i <= 20; i++) begin
      step(0, 1, 1, 1, 1, 0, i, (i > 15) ? 15 : i, 0, 0);
      if (i % 5 == 0)
        step(0, 0, 1, 1, 1, 0, i, (i > 15) ? 15 : i, 0, 0);
    end
    @(negedge clk);
    bus.valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/diag_monitor.md
DIAG_MONITOR -- requirements
Module: diag_monitor

Interface
REQ-001 Parameter W, default 4, sample width of x/y; SHALL support 2..16.
REQ-002 Parameter CW, default 8, width of sample_cnt; SHALL support 4..16.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 valid  input  1  x/y carry a sample this cycle.
REQ-006 x  input  W  producer's X value.
REQ-007 y  input  W  producer's Y value.
REQ-008 state  output  2  FSM state: IDLE=0, EQUAL=1, AHEAD=2, FAIL=3.
REQ-009 ok  output  1  high whenever state != FAIL.
REQ-010 cause  output  2  failure cause: NONE=0, ORDER=1, HOLD=2.
REQ-011 sample_cnt  output  CW  valid samples accepted since reset, saturating.

Function
REQ-012 All outputs SHALL be registered; a sample presented in cycle N SHALL be reflected in the outputs in cycle N+1.
REQ-013 Cycles with valid=0 SHALL leave state, cause, sample_cnt and the stored previous sample unchanged.
REQ-014 IDLE, on a valid sample: x<y -> FAIL/ORDER; x==y -> EQUAL; x>y -> AHEAD; no HOLD check.
REQ-015 EQUAL, on a valid sample: x<y -> FAIL/ORDER; x==y -> EQUAL; x>y -> AHEAD.
REQ-016 AHEAD, on a valid sample: x<y -> FAIL/ORDER; else y != previous y -> FAIL/HOLD; else x==y -> EQUAL, x>y -> AHEAD.
REQ-017 ORDER SHALL take priority over HOLD when both conditions hold in the same sample.
REQ-018 FAIL SHALL be sticky; state and cause SHALL hold until reset, regardless of valid.
REQ-019 Comparisons SHALL be unsigned on W bits; wrap-around (e.g. x from 2^W-1 to 0) is not special-cased and is judged only by the ORDER/HOLD rules.
REQ-020 The previous sample register SHALL load y on every accepted valid sample, including the one entering FAIL.
REQ-021 sample_cnt SHALL increment by 1 on each valid sample, including in FAIL, and saturate at 2^CW-1 without wrapping.
REQ-022 The block SHALL carry the safety property "ok is always high", expressed as an assert property on a wire, matching the producer-side property form.

Reset
REQ-023 reset=1 at a clock edge SHALL force state=IDLE, cause=NONE, sample_cnt=0 and previous y=0, so that ok=1.
REQ-024 reset SHALL override a simultaneous valid sample; that sample SHALL be discarded and not counted.
REQ-025 reset asserted mid-operation, including in FAIL, SHALL recover fully in one cycle.
REQ-026 Initial values SHALL equal the reset values for formal runs without a reset cycle.

Configuration
REQ-027 Macro DIAG_MONITOR_TRACE_EN: when defined, SHALL add outputs fail_x[W] and fail_y[W], latching x/y of the sample that entered FAIL, and 0 otherwise (including after reset).
REQ-028 When DIAG_MONITOR_TRACE_EN is undefined, the fail_x/fail_y ports and their registers SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 Package diag_pkg SHALL hold the state encoding, the cause encoding and the default W.
REQ-030 Sub-module diag_sat_counter (parameter CW; ports clk, reset, inc, count) SHALL implement sample_cnt; all other logic is flat.

Verification
REQ-031 Reset, then valid samples (0,0),(1,1),(8,1),(12,1) -> state EQUAL,EQUAL,AHEAD,AHEAD; ok=1; sample_cnt=4.
REQ-032 In AHEAD with previous y=1, sample (12,2) -> state=FAIL, cause=HOLD, ok=0 next cycle.
REQ-033 From IDLE, sample (3,5) -> FAIL/ORDER; with TRACE_EN, fail_x=3 and fail_y=5.
REQ-034 In AHEAD with previous y=4, sample (2,7) -> cause=ORDER, not HOLD.
REQ-035 In FAIL, assert reset together with valid (5,5) -> next cycle IDLE, cause=NONE, sample_cnt=0, ok=1.
REQ-036 With CW=4, drive 20 valid samples of (1,1) -> sample_cnt stays at 15; valid=0 gaps leave sample_cnt unchanged.
